// File: rtl/count_monitor.sv
// Watches a free-running 4-bit counter and reports WRAP/SKIP/STALL/RESUME events with timestamps.
// Events appear one cycle after the triggering count; evt_ready gates a 2-deep queue, overflow drops the new event.

// Small synchronous FIFO; a push into a full FIFO is accepted only when a pop frees the head that cycle.
module count_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push_vld,
  input  logic [W-1:0] push_dat,
  input  logic         pop_rdy,
  output logic         head_vld,
  output logic [W-1:0] head_dat,
  output logic         drop
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] rd_ptr_q;
  logic [AW-1:0] wr_ptr_q;
  logic [CW-1:0] cnt_q;
  logic          full;
  logic          do_pop;
  logic          do_push;

  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction

  assign full     = (cnt_q == CW'(DEPTH));
  assign do_pop   = pop_rdy && (cnt_q != '0);
  assign do_push  = push_vld && (!full || do_pop);
  assign drop     = push_vld && full && !do_pop;
  assign head_vld = (cnt_q != '0);
  assign head_dat = mem_q[rd_ptr_q];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= push_dat;
        wr_ptr_q        <= ptr_inc(wr_ptr_q);
      end
      if (do_pop) begin
        rd_ptr_q <= ptr_inc(rd_ptr_q);
      end
      if (do_push && !do_pop) begin
        cnt_q <= cnt_q + CW'(1);
      end else if (!do_push && do_pop) begin
        cnt_q <= cnt_q - CW'(1);
      end
    end
  end

endmodule

module count_monitor #(
  parameter int STALL_LIMIT = 8,
  parameter int STAT_W      = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [3:0]        count,
  input  logic              evt_ready,
  output logic              evt_valid,
  output logic [1:0]        evt_code,
  output logic [STAT_W-1:0] evt_stamp,
  output logic [STAT_W-1:0] wrap_cnt,
  output logic [STAT_W-1:0] err_cnt,
  output logic              ovf
);

  localparam int RUN_W = 8;

  typedef enum logic [1:0] {
    EVT_WRAP   = 2'd0,
    EVT_SKIP   = 2'd1,
    EVT_STALL  = 2'd2,
    EVT_RESUME = 2'd3
  } evt_code_t;

  typedef struct packed {
    evt_code_t         code;
    logic [STAT_W-1:0] stamp;
  } evt_t;

  typedef enum logic [1:0] {
    ST_INIT    = 2'd0,
    ST_TRACK   = 2'd1,
    ST_STALLED = 2'd2
  } state_t;

  state_t            state_q;
  state_t            state_d;
  logic [3:0]        prev_q;
  logic [3:0]        prev_inc;
  logic [STAT_W-1:0] cyc_q;
  logic [RUN_W-1:0]  run_q;

  logic              is_same;
  logic              is_inc;
  logic              is_wrap;
  logic              stall_hit;

  logic              push_vld;
  evt_t              push_evt;
  logic              wrap_inc;
  logic              err_inc;
  logic              run_clr;
  logic              run_inc;

  evt_t              head_evt;
  logic              head_vld;
  logic              drop;

  assign prev_inc  = prev_q + 4'd1;
  assign is_same   = (count == prev_q);
  assign is_inc    = (count == prev_inc);
  assign is_wrap   = (prev_q == 4'hF) && (count == 4'h0);
  // The current same-count cycle is the (run_q+1)th repeat; the stall fires when that reaches LIMIT-1.
  assign stall_hit = (run_q == RUN_W'(STALL_LIMIT - 2));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_INIT;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_INIT:    state_d = ST_TRACK;
      ST_TRACK:   if (!is_wrap && is_same && stall_hit) state_d = ST_STALLED;
      ST_STALLED: if (!is_same) state_d = ST_TRACK;
      default:    state_d = ST_INIT;
    endcase
  end

  always_comb begin
    push_vld       = 1'b0;
    push_evt.code  = EVT_WRAP;
    push_evt.stamp = cyc_q;
    wrap_inc       = 1'b0;
    err_inc        = 1'b0;
    run_clr        = 1'b0;
    run_inc        = 1'b0;
    case (state_q)
      ST_TRACK: begin
        if (is_wrap) begin
          push_vld      = 1'b1;
          push_evt.code = EVT_WRAP;
          wrap_inc      = 1'b1;
          run_clr       = 1'b1;
        end else if (is_same) begin
          run_inc = 1'b1;
          if (stall_hit) begin
            push_vld      = 1'b1;
            push_evt.code = EVT_STALL;
          end
        end else if (!is_inc) begin
          push_vld      = 1'b1;
          push_evt.code = EVT_SKIP;
          err_inc       = 1'b1;
          run_clr       = 1'b1;
        end else begin
          run_clr = 1'b1;
        end
      end
      ST_STALLED: begin
        // Any change leaves the stall; a 15->0 still counts as a wrap but is reported only as RESUME.
        if (!is_same) begin
          push_vld      = 1'b1;
          push_evt.code = EVT_RESUME;
          wrap_inc      = is_wrap;
          run_clr       = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      prev_q   <= '0;
      cyc_q    <= '0;
      run_q    <= '0;
      wrap_cnt <= '0;
      err_cnt  <= '0;
      ovf      <= 1'b0;
    end else begin
      prev_q <= count;
      cyc_q  <= cyc_q + STAT_W'(1);
      if (run_clr) begin
        run_q <= '0;
      end else if (run_inc) begin
        run_q <= run_q + RUN_W'(1);
      end
      if (wrap_inc && (wrap_cnt != '1)) begin
        wrap_cnt <= wrap_cnt + STAT_W'(1);
      end
      if (err_inc && (err_cnt != '1)) begin
        err_cnt <= err_cnt + STAT_W'(1);
      end
      if (drop) begin
        ovf <= 1'b1;
      end
    end
  end

  count_fifo #(
    .W     ($bits(evt_t)),
    .DEPTH (2)
  ) u_evt_fifo (
    .clk      (clk),
    .rst      (rst),
    .push_vld (push_vld),
    .push_dat (push_evt),
    .pop_rdy  (evt_ready),
    .head_vld (head_vld),
    .head_dat (head_evt),
    .drop     (drop)
  );

  assign evt_valid = head_vld;
  assign evt_code  = head_evt.code;
  assign evt_stamp = head_evt.stamp;

endmodule

// File: tb/tb_count_monitor.sv
// Directed table of per-cycle vectors for count_monitor, plus hand sequences for stall/wrap interplay and saturation.
module tb_count_monitor;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] count;
  logic       evt_ready;
  logic       evt_valid;
  logic [1:0] evt_code;
  logic [7:0] evt_stamp;
  logic [7:0] wrap_cnt;
  logic [7:0] err_cnt;
  logic       ovf;

  int checks = 0;
  int errors = 0;

  localparam logic [1:0] C_WRAP = 2'd0, C_SKIP = 2'd1, C_STALL = 2'd2, C_RESUME = 2'd3;

  typedef struct {
    logic       rst;
    logic [3:0] cnt;
    logic       rdy;
    logic       vld;
    logic [1:0] code;
    logic [7:0] stamp;
    logic [7:0] wrap;
    logic [7:0] err;
    logic       ovf;
  } vec_t;

  vec_t tbl[$];

  count_monitor #(.STALL_LIMIT(8), .STAT_W(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .count     (count),
    .evt_ready (evt_ready),
    .evt_valid (evt_valid),
    .evt_code  (evt_code),
    .evt_stamp (evt_stamp),
    .wrap_cnt  (wrap_cnt),
    .err_cnt   (err_cnt),
    .ovf       (ovf)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish within bound");
    $fatal(1, "timeout");
  end

  task automatic add(input logic r, input logic [3:0] c, input logic rd, input logic v,
                     input logic [1:0] cd, input logic [7:0] st, input logic [7:0] w,
                     input logic [7:0] e, input logic o);
    vec_t t;
    t.rst = r; t.cnt = c; t.rdy = rd; t.vld = v; t.code = cd;
    t.stamp = st; t.wrap = w; t.err = e; t.ovf = o;
    tbl.push_back(t);
  endtask

  task automatic step(input logic r, input logic [3:0] c, input logic rd);
    rst = r; count = c; evt_ready = rd;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  initial begin
    rst = 1'b1; count = 4'd0; evt_ready = 1'b1;

    // Reset, then a clean 0..15,0 sweep: one WRAP at cycle 16.
    add(1, 0, 1, 0, 0, 0, 0, 0, 0);
    add(1, 0, 1, 0, 0, 0, 0, 0, 0);
    for (int k = 0; k < 16; k++) add(0, 4'(k), 1, 0, 0, 0, 0, 0, 0);
    add(0, 0, 1, 1, C_WRAP, 16, 1, 0, 0);
    // Stall: 5 held for 10 cycles (cycles 21..30), STALL on the 8th, RESUME on 6.
    for (int k = 1; k <= 4; k++) add(0, 4'(k), 1, 0, 0, 0, 1, 0, 0);
    for (int j = 0; j < 7; j++) add(0, 5, 1, 0, 0, 0, 1, 0, 0);
    add(0, 5, 1, 1, C_STALL, 28, 1, 0, 0);
    add(0, 5, 1, 0, 0, 0, 1, 0, 0);
    add(0, 5, 1, 0, 0, 0, 1, 0, 0);
    add(0, 6, 1, 1, C_RESUME, 31, 1, 0, 0);
    // Run up to a second wrap, then 3,4,9 gives a SKIP stamped 46.
    for (int k = 7; k <= 15; k++) add(0, 4'(k), 1, 0, 0, 0, 1, 0, 0);
    add(0, 0, 1, 1, C_WRAP, 41, 2, 0, 0);
    for (int k = 1; k <= 4; k++) add(0, 4'(k), 1, 0, 0, 0, 2, 0, 0);
    add(0, 9, 1, 1, C_SKIP, 46, 2, 1, 0);
    // Full FIFO with a same-cycle pop: push accepted, ovf stays clear.
    add(0, 10, 1, 0, 0, 0, 2, 1, 0);
    add(0, 13, 0, 1, C_SKIP, 48, 2, 2, 0);
    add(0, 2, 0, 1, C_SKIP, 48, 2, 3, 0);
    add(0, 7, 1, 1, C_SKIP, 49, 2, 4, 0);
    add(0, 8, 1, 1, C_SKIP, 50, 2, 4, 0);
    add(0, 9, 1, 0, 0, 0, 2, 4, 0);
    // Three SKIPs with no ready: third dropped, ovf set, two drain in order.
    add(0, 14, 0, 1, C_SKIP, 53, 2, 5, 0);
    add(0, 3, 0, 1, C_SKIP, 53, 2, 6, 0);
    add(0, 11, 0, 1, C_SKIP, 53, 2, 7, 1);
    add(0, 12, 1, 1, C_SKIP, 54, 2, 7, 1);
    add(0, 13, 1, 0, 0, 0, 2, 7, 1);
    add(0, 1, 0, 1, C_SKIP, 58, 2, 8, 1);
    add(0, 6, 0, 1, C_SKIP, 58, 2, 9, 1);
    // Reset with two queued events and ready high; INIT cycle shows 9 without a SKIP.
    add(1, 7, 1, 0, 0, 0, 0, 0, 0);
    add(0, 9, 1, 0, 0, 0, 0, 0, 0);
    add(0, 10, 1, 0, 0, 0, 0, 0, 0);

    foreach (tbl[i]) begin
      step(tbl[i].rst, tbl[i].cnt, tbl[i].rdy);
      chk($sformatf("row%0d evt_valid", i), 32'(evt_valid), 32'(tbl[i].vld));
      chk($sformatf("row%0d wrap_cnt", i), 32'(wrap_cnt), 32'(tbl[i].wrap));
      chk($sformatf("row%0d err_cnt", i), 32'(err_cnt), 32'(tbl[i].err));
      chk($sformatf("row%0d ovf", i), 32'(ovf), 32'(tbl[i].ovf));
      if (tbl[i].vld || tbl[i].rst) begin
        chk($sformatf("row%0d evt_code", i), 32'(evt_code), 32'(tbl[i].code));
        chk($sformatf("row%0d evt_stamp", i), 32'(evt_stamp), 32'(tbl[i].stamp));
      end
    end

    // Stall at 15, then 0: RESUME only, but wrap_cnt still counts it.
    for (int k = 11; k <= 15; k++) step(0, 4'(k), 1);
    for (int j = 0; j < 7; j++) step(0, 15, 1);
    chk("stall15 valid", 32'(evt_valid), 1);
    chk("stall15 code", 32'(evt_code), 32'(C_STALL));
    chk("stall15 stamp", 32'(evt_stamp), 13);
    step(0, 15, 1);
    chk("stalled hold quiet", 32'(evt_valid), 0);
    step(0, 0, 1);
    chk("resume wrap valid", 32'(evt_valid), 1);
    chk("resume wrap code", 32'(evt_code), 32'(C_RESUME));
    chk("resume wrap stamp", 32'(evt_stamp), 15);
    chk("resume wrap wrap_cnt", 32'(wrap_cnt), 1);
    // Stall at 0, then a jump to 9: RESUME without touching err_cnt.
    for (int j = 0; j < 7; j++) step(0, 0, 1);
    chk("stall0 code", 32'(evt_code), 32'(C_STALL));
    chk("stall0 stamp", 32'(evt_stamp), 22);
    step(0, 9, 1);
    chk("resume jump code", 32'(evt_code), 32'(C_RESUME));
    chk("resume jump stamp", 32'(evt_stamp), 23);
    chk("resume jump err_cnt", 32'(err_cnt), 0);
    chk("resume jump wrap_cnt", 32'(wrap_cnt), 1);

    // 260 back-to-back SKIPs: err_cnt saturates, stamp wraps modulo 256.
    for (int i = 0; i < 260; i++) begin
      step(0, (i % 2 == 0) ? 4'd2 : 4'd9, 1);
      if (i == 254) chk("err_cnt reaches max", 32'(err_cnt), 255);
    end
    chk("err_cnt saturated", 32'(err_cnt), 255);
    chk("sat code", 32'(evt_code), 32'(C_SKIP));
    chk("sat stamp wraps", 32'(evt_stamp), 27);
    chk("sat ovf clear", 32'(ovf), 0);
    chk("sat wrap_cnt", 32'(wrap_cnt), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/count_monitor.md
COUNT_MONITOR -- requirements
Module: count_monitor

Interface
REQ-001 Parameter STALL_LIMIT, default 8: consecutive unchanged-count cycles that declare a stall (legal 2..255).
REQ-002 Parameter STAT_W, default 8: width of the timestamp and statistic counters.
REQ-003 clk  input  1  single clock; all logic on rising edge.
REQ-004 rst  input  1  reset; synchronous, active-high.
REQ-005 count  input  4  free-running counter value from the upstream counter stage.
REQ-006 evt_ready  input  1  consumer accepts the head event when high with evt_valid.
REQ-007 evt_valid  output  1  head event present.
REQ-008 evt_code  output  2  event type: 0 WRAP, 1 SKIP, 2 STALL, 3 RESUME.
REQ-009 evt_stamp  output  STAT_W  cycle timestamp of the event.
REQ-010 wrap_cnt  output  STAT_W  number of WRAP detections, saturating.
REQ-011 err_cnt  output  STAT_W  number of SKIP detections, saturating.
REQ-012 ovf  output  1  sticky flag: an event was dropped.

Function
REQ-013 The block SHALL register count into prev_q every cycle and compare the live count against prev_q.
REQ-014 The block SHALL run a free-running STAT_W-bit cycle counter, cleared by reset, that wraps modulo 2^STAT_W and is sampled as evt_stamp.
REQ-015 FSM states SHALL be INIT, TRACK and STALLED.
REQ-016 INIT: the first cycle after reset release captures prev_q, generates no event and moves to TRACK.
REQ-017 TRACK: prev_q=15 and count=0 SHALL generate WRAP, increment wrap_cnt and clear the same-count run length.
REQ-018 TRACK: count not equal to prev_q+1 (mod 16) and not equal to prev_q SHALL generate SKIP and increment err_cnt.
REQ-019 TRACK: count equal to prev_q SHALL increment the run length; when the run length reaches STALL_LIMIT-1, the block SHALL generate STALL once and enter STALLED.
REQ-020 STALLED: count equal to prev_q SHALL generate no event; any change SHALL generate only RESUME, return to TRACK and clear the run length.
REQ-021 STALLED: a 15->0 change SHALL still increment wrap_cnt, but the event code is RESUME; a non-+1 change SHALL not increment err_cnt.
REQ-022 At most one event SHALL be generated per cycle.
REQ-023 Each event SHALL be written at the clock edge that ends the cycle in which count shows the triggering value; evt_valid rises the next cycle (1-cycle latency).
REQ-024 Events SHALL be held in a 2-entry FIFO, oldest at the head; the head is popped when evt_valid and evt_ready are both high.
REQ-025 evt_code and evt_stamp SHALL stay stable while evt_valid=1 and evt_ready=0.
REQ-026 A push while the FIFO is full SHALL be dropped and SHALL set ovf, unless a pop occurs the same cycle, in which case the push succeeds.
REQ-027 A push and pop in the same cycle on a 1-entry FIFO SHALL leave exactly one entry: the new event.
REQ-028 wrap_cnt and err_cnt SHALL saturate at 2^STAT_W-1.
REQ-029 ovf SHALL clear only on reset.

Reset
REQ-030 While rst=1 at a clock edge: FSM=INIT, FIFO empty, evt_valid=0, evt_code=0, evt_stamp=0, wrap_cnt=0, err_cnt=0, ovf=0, run length=0, cycle counter=0, prev_q=0.
REQ-031 Reset asserted mid-operation SHALL discard all queued events and statistics at the next edge, regardless of evt_ready.

Verification
REQ-032 Reset for 2 cycles, then count 0,1,...,15,0 with evt_ready=1 -> exactly one WRAP; evt_valid high 1 cycle after count=0; wrap_cnt=1; err_cnt=0.
REQ-033 count 3,4,9 in TRACK -> one SKIP with stamp equal to the cycle showing 9; err_cnt=1.
REQ-034 count held at 5 for 10 cycles, then 6, with STALL_LIMIT=8 -> STALL on the 8th cycle at 5, then RESUME on the cycle showing 6, with no other events.
REQ-035 evt_ready=0 and three SKIPs -> FIFO holds the first two events, ovf=1; then evt_ready=1 -> exactly two events drain in order.
REQ-036 FIFO full, a new event and evt_ready=1 in the same cycle -> ovf stays 0; the new event becomes the second entry.
REQ-037 rst=1 while 2 events are queued -> at the next edge evt_valid=0, wrap_cnt=0, ovf=0; the first post-reset cycle produces no event.
